// File: rtl/move_tx.sv
// rtl/move_tx.sv - serial transmitter for one Go move as a header/move/check packet
module move_tx #(
    parameter int          CLKS_PER_BIT = 564,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          GAP_BITS     = 1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       tx_ready,
    input  logic [7:0] move,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic       dropped
);

    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    // A zero-length gap still needs a legal counter width; the GAP state is then unreachable.
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t            state,    state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [GAP_W-1:0]  gap_cnt,  gap_nxt;
    logic [2:0]        bit_cnt,  bit_nxt;
    logic [1:0]        byte_idx, idx_nxt;
    logic [7:0]        shift,    shift_nxt;
    logic [7:0]        move_lat, move_nxt;
    logic              tx_nxt, busy_nxt, done_nxt, dropped_nxt;

    // State and registered outputs; reset forces the line idle immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            baud_cnt <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            move_lat <= '0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            gap_cnt  <= gap_nxt;
            bit_cnt  <= bit_nxt;
            byte_idx <= idx_nxt;
            shift    <= shift_nxt;
            move_lat <= move_nxt;
            tx_out   <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            dropped  <= dropped_nxt;
        end
    end

    // Next-state logic; tx_nxt is the value the line takes after the coming edge.
    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_cnt;
        gap_nxt     = gap_cnt;
        bit_nxt     = bit_cnt;
        idx_nxt     = byte_idx;
        shift_nxt   = shift;
        move_nxt    = move_lat;
        tx_nxt      = tx_out;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        dropped_nxt = tx_ready && (state != IDLE);

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (tx_ready) begin
                    move_nxt  = move;
                    shift_nxt = HEADER;
                    idx_nxt   = 2'd0;
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        tx_nxt  = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    if (byte_idx == 2'd2) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        tx_nxt    = 1'b1;
                    end else begin
                        idx_nxt   = byte_idx + 2'd1;
                        shift_nxt = (byte_idx == 2'd0) ? move_lat : (HEADER ^ move_lat);
                        if (GAP_BITS == 0) begin
                            state_nxt = START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = GAP;
                            gap_nxt   = '0;
                            tx_nxt    = 1'b1;
                        end
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt   = '0;
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_move_tx.sv
// tb/tb_move_tx.sv - scoreboard bench for move_tx with a mid-bit sampling receiver model
module tb_move_tx;

    localparam int         CPB_A = 4;
    localparam int         GAP_A = 1;
    localparam int         CPB_B = 2;
    localparam int         GAP_B = 0;
    localparam logic [7:0] HDR   = 8'hA5;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b1;
    logic       tx_ready_a = 1'b0, tx_ready_b = 1'b0;
    logic [7:0] move_a = 8'h00, move_b = 8'h00;
    logic       tx_a, busy_a, done_a, dropped_a;
    logic       tx_b, busy_b, done_b, dropped_b;

    always #5 clk_in = ~clk_in;

    move_tx #(.CLKS_PER_BIT(CPB_A), .HEADER(HDR), .GAP_BITS(GAP_A)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .tx_ready(tx_ready_a), .move(move_a),
        .tx_out(tx_a), .busy(busy_a), .done(done_a), .dropped(dropped_a)
    );

    move_tx #(.CLKS_PER_BIT(CPB_B), .HEADER(HDR), .GAP_BITS(GAP_B)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .tx_ready(tx_ready_b), .move(move_b),
        .tx_out(tx_b), .busy(busy_b), .done(done_b), .dropped(dropped_b)
    );

    typedef struct packed {
        logic [2:0][7:0] b;
        int              start;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc  = 0;
    int   sel   = 0;

    function automatic logic line(); return (sel != 0) ? tx_b      : tx_a;      endfunction
    function automatic logic bz();   return (sel != 0) ? busy_b    : busy_a;    endfunction
    function automatic logic dn();   return (sel != 0) ? done_b    : done_a;    endfunction
    function automatic logic drp();  return (sel != 0) ? dropped_b : dropped_a; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // One clock of observation at the falling edge; dropped pulses are matched here.
    task automatic tick();
        @(negedge clk_in);
        ncyc++;
        if (drp() === 1'b1) begin
            if (drop_q.size() == 0) fail("unexpected_dropped_pulse");
            else chk("dropped_cycle", ncyc, drop_q.pop_front());
        end
    endtask

    // Receiver model: records a whole packet from its first low cycle and decodes it.
    task automatic watch_packet();
        int         cpb, g, frame, len, busy_n, done_n, errs, lows, t0;
        logic       s[$];
        logic [7:0] got[3];
        logic       sb;
        exp_t       e;
        bit         have;
        cpb    = (sel != 0) ? CPB_B : CPB_A;
        g      = (sel != 0) ? GAP_B : GAP_A;
        frame  = (10 + g) * cpb;
        len    = 30 * cpb + 2 * g * cpb;
        busy_n = 0; done_n = 0; errs = 0; lows = 0;
        t0     = ncyc;
        e      = '0;
        have   = (exp_q.size() != 0);
        if (have) e = exp_q.pop_front();
        else fail("unexpected_packet");
        for (int k = 0; k < len; k++) begin
            if (k > 0) tick();
            if (rst_n_in !== 1'b1) return;
            s.push_back(line());
            busy_n += int'(bz());
            done_n += int'(dn());
        end
        tick();
        if (rst_n_in !== 1'b1 || !have) return;
        chk("start_cycle", t0, e.start);
        chk("busy_cycles", busy_n, len);
        chk("done_before_end", done_n, 0);
        chk("done_at_end", dn(), 1);
        chk("busy_at_end", bz(), 0);
        for (int b = 0; b < 3; b++) begin
            int base;
            base = b * frame;
            for (int j = 0; j < 10; j++) begin
                sb = s[base + j * cpb + cpb / 2];
                for (int c = 0; c < cpb; c++) if (s[base + j * cpb + c] !== sb) errs++;
                if (j >= 1 && j <= 8) got[b][j-1] = sb;
            end
            chk($sformatf("byte%0d_start_bit", b), s[base + cpb / 2], 0);
            chk($sformatf("byte%0d_stop_bit", b), s[base + 9 * cpb + cpb / 2], 1);
            if (b < 2) for (int c = 10 * cpb; c < frame; c++) if (s[base + c] !== 1'b1) lows++;
            chk($sformatf("byte%0d_value", b), got[b], e.b[b]);
        end
        chk("bit_width_errors", errs, 0);
        chk("gap_low_cycles", lows, 0);
        chk("rx_check_ok", (got[0] == HDR) && (got[2] == (HDR ^ got[1])), 1);
    endtask

    initial begin
        forever begin
            tick();
            if (rst_n_in === 1'b1 && line() === 1'b0) watch_packet();
        end
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // One-cycle strobe; move is scrambled right after the accepting edge.
    task automatic pulse(input logic [7:0] mv);
        if (sel == 0) begin tx_ready_a = 1'b1; move_a = mv; end
        else          begin tx_ready_b = 1'b1; move_b = mv; end
        step();
        tx_ready_a = 1'b0;
        tx_ready_b = 1'b0;
        move_a = 8'($urandom);
        move_b = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] mv);
        exp_t e;
        e.b     = {HDR ^ mv, mv, HDR};
        e.start = ncyc + 1;
        exp_q.push_back(e);
        pulse(mv);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dn() !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) fail("done_timeout");
    endtask

    initial begin
        int lows;
        #1 rst_n_in = 1'b0;
        #2;
        chk("rst_tx_a", tx_a, 1);       chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);   chk("rst_dropped_a", dropped_a, 0);
        chk("rst_tx_b", tx_b, 1);       chk("rst_busy_b", busy_b, 0);
        repeat (3) step();
        rst_n_in = 1'b1;
        repeat (3) step();

        send(8'h35); wait_done(); repeat (5) step();
        send(8'hFF); wait_done(); repeat (3) step();

        send(8'h5C);
        repeat (9) step();
        tx_ready_a = 1'b1; move_a = 8'h00;
        drop_q.push_back(ncyc + 1);
        step();
        tx_ready_a = 1'b0;
        wait_done();
        repeat (20) step();
        chk("no_second_packet", exp_q.size(), 0);

        send(8'h77); wait_done();
        send(8'h12); wait_done(); repeat (4) step();

        send(8'h3C);
        repeat (55) step();
        chk("pre_reset_busy", busy_a, 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("reset_tx_immediate", tx_a, 1);
        chk("reset_busy_immediate", busy_a, 0);
        step(); step();
        rst_n_in = 1'b1;
        lows = 0;
        repeat (20) begin
            step();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        chk("idle_after_reset", lows, 0);
        chk("exp_q_after_reset", exp_q.size(), 0);
        send(8'hC3); wait_done(); repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            send(8'($urandom));
            wait_done();
            if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 6)) step();
        end

        repeat (4) step();
        sel = 1;
        send(8'h35); wait_done();
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom));
            wait_done();
            if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 4)) step();
        end

        repeat (10) step();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("drop_q_drained", drop_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
